// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// EX-stage forwarding select generation and a saturating bubble counter.
module id_ex_forward_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic [4:0]        mem_rd,
    input  logic              mem_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic              wb_reg_write,
    output logic              ex_valid,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              r_ex_valid;
    logic [4:0]        r_ex_rs1;
    logic [4:0]        r_ex_rs2;
    logic [4:0]        r_ex_rd;
    logic [DATA_W-1:0] r_ex_rs1_data;
    logic [DATA_W-1:0] r_ex_rs2_data;
    logic [DATA_W-1:0] r_ex_imm;
    logic              r_ex_reg_write;
    logic              r_ex_mem_read;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_hazard;
    logic              w_bubble;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    // A load in EX whose result ID needs cannot be forwarded in time.
    assign w_hazard = r_ex_valid & r_ex_mem_read & (r_ex_rd != 5'd0) & id_valid &
                      ((id_rs1 == r_ex_rd) | (id_rs2 == r_ex_rd));
    assign w_bubble = flush | w_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_rd        <= '0;
            r_ex_rs1_data  <= '0;
            r_ex_rs2_data  <= '0;
            r_ex_imm       <= '0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_ctrl      <= '0;
            r_bubble_cnt   <= '0;
        end else if (w_bubble) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_rd        <= '0;
            r_ex_rs1_data  <= '0;
            r_ex_rs2_data  <= '0;
            r_ex_imm       <= '0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_ctrl      <= '0;
            if (r_bubble_cnt != {CNT_W{1'b1}}) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end else begin
            r_ex_valid     <= id_valid;
            r_ex_rs1       <= id_rs1;
            r_ex_rs2       <= id_rs2;
            r_ex_rd        <= id_rd;
            r_ex_rs1_data  <= id_rs1_data;
            r_ex_rs2_data  <= id_rs2_data;
            r_ex_imm       <= id_imm;
            r_ex_reg_write <= id_reg_write & id_valid;
            r_ex_mem_read  <= id_mem_read & id_valid;
            r_ex_ctrl      <= id_ctrl;
        end
    end

    // MEM result is younger than WB, so it wins; x0 is never forwarded.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (r_ex_valid & mem_reg_write & (mem_rd != 5'd0) & (mem_rd == r_ex_rs1)) begin
            w_fwd_a = 2'b10;
        end else if (r_ex_valid & wb_reg_write & (wb_rd != 5'd0) & (wb_rd == r_ex_rs1)) begin
            w_fwd_a = 2'b01;
        end
        if (r_ex_valid & mem_reg_write & (mem_rd != 5'd0) & (mem_rd == r_ex_rs2)) begin
            w_fwd_b = 2'b10;
        end else if (r_ex_valid & wb_reg_write & (wb_rd != 5'd0) & (wb_rd == r_ex_rs2)) begin
            w_fwd_b = 2'b01;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_rs1       = r_ex_rs1;
    assign ex_rs2       = r_ex_rs2;
    assign ex_rd        = r_ex_rd;
    assign ex_rs1_data  = r_ex_rs1_data;
    assign ex_rs2_data  = r_ex_rs2_data;
    assign ex_imm       = r_ex_imm;
    assign ex_reg_write = r_ex_reg_write;
    assign ex_mem_read  = r_ex_mem_read;
    assign ex_ctrl      = r_ex_ctrl;
    assign fwd_a_sel    = w_fwd_a;
    assign fwd_b_sel    = w_fwd_b;
    assign stall        = w_hazard & ~flush;
    assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Directed bench for id_ex_forward_stage: reset, pass-through, forwarding,
// load-use stall, flush priority and counter saturation (second instance, CNT_W=4).
module tb_id_ex_forward_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_reg_write, id_mem_read;
    logic [7:0]  id_ctrl;
    logic        flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;

    logic        ex_valid;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
    logic        ex_reg_write, ex_mem_read;
    logic [7:0]  ex_ctrl;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall;
    logic [15:0] bubble_cnt;

    logic        s_ex_valid;
    logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [31:0] s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
    logic        s_ex_reg_write, s_ex_mem_read;
    logic [7:0]  s_ex_ctrl;
    logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
    logic        s_stall;
    logic [3:0]  s_bubble_cnt;

    int checks;
    int errors;

    id_ex_forward_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
        .flush(flush), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_forward_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
        .flush(flush), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .ex_valid(s_ex_valid), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
        .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm),
        .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read), .ex_ctrl(s_ex_ctrl),
        .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel), .stall(s_stall),
        .bubble_cnt(s_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_id();
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_ctrl = 8'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_id();
        flush = 1'b0;
        mem_rd = 5'd3; mem_reg_write = 1'b1;
        wb_rd = 5'd4; wb_reg_write = 1'b1;

        // Reset held two cycles with a live ID instruction
        rst = 1'b1;
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd5;
        id_reg_write = 1'b1; id_mem_read = 1'b1;
        tick();
        tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_reg_write", ex_reg_write, 0);
        chk("rst_fwd_a", fwd_a_sel, 0);
        chk("rst_fwd_b", fwd_b_sel, 0);
        chk("rst_stall", stall, 0);
        chk("rst_bubble_cnt", bubble_cnt, 0);

        // Pass-through
        rst = 1'b0;
        mem_rd = 5'd0; mem_reg_write = 1'b0; wb_rd = 5'd0; wb_reg_write = 1'b0;
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd5;
        id_rs1_data = 32'h12345678; id_rs2_data = 32'hAAAA5555; id_imm = 32'hFFFFFFF0;
        id_reg_write = 1'b1; id_mem_read = 1'b0; id_ctrl = 8'hA5;
        tick();
        chk("pt_ex_rs1_data", ex_rs1_data, 32'h12345678);
        chk("pt_ex_rs2_data", ex_rs2_data, 32'hAAAA5555);
        chk("pt_ex_imm", ex_imm, 32'hFFFFFFF0);
        chk("pt_ex_rd", ex_rd, 5);
        chk("pt_ex_rs1", ex_rs1, 3);
        chk("pt_ex_rs2", ex_rs2, 4);
        chk("pt_ex_valid", ex_valid, 1);
        chk("pt_ex_reg_write", ex_reg_write, 1);
        chk("pt_ex_mem_read", ex_mem_read, 0);
        chk("pt_ex_ctrl", ex_ctrl, 8'hA5);
        chk("pt_bubble_cnt", bubble_cnt, 0);
        chk("pt_stall", stall, 0);

        // Forwarding priority, EX holds rs1=3 rs2=4
        mem_rd = 5'd3; mem_reg_write = 1'b1; wb_rd = 5'd3; wb_reg_write = 1'b1;
        settle();
        chk("fwd_mem_over_wb_a", fwd_a_sel, 2'b10);
        chk("fwd_mem_over_wb_b", fwd_b_sel, 2'b00);
        mem_reg_write = 1'b0;
        settle();
        chk("fwd_wb_a", fwd_a_sel, 2'b01);
        wb_rd = 5'd4;
        settle();
        chk("fwd_wb_b", fwd_b_sel, 2'b01);
        chk("fwd_wb_b_a_clear", fwd_a_sel, 2'b00);
        mem_rd = 5'd4; mem_reg_write = 1'b1;
        settle();
        chk("fwd_mem_b", fwd_b_sel, 2'b10);
        mem_rd = 5'd0; wb_rd = 5'd0;
        settle();
        chk("fwd_x0_a", fwd_a_sel, 2'b00);
        chk("fwd_x0_b", fwd_b_sel, 2'b00);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;

        // Load-use: load x7 into EX
        id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd7;
        id_reg_write = 1'b1; id_mem_read = 1'b1; id_ctrl = 8'h11;
        tick();
        chk("lu_ex_mem_read", ex_mem_read, 1);
        id_rs1 = 5'd8; id_rs2 = 5'd6; id_rd = 5'd9; id_mem_read = 1'b0;
        id_rs2_data = 32'h0BADF00D; id_ctrl = 8'h22;
        settle();
        chk("lu_no_match_stall", stall, 0);
        id_valid = 1'b0; id_rs2 = 5'd7;
        settle();
        chk("lu_id_invalid_stall", stall, 0);
        id_valid = 1'b1;
        settle();
        chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble_ex_valid", ex_valid, 0);
        chk("lu_bubble_ex_rd", ex_rd, 0);
        chk("lu_bubble_ex_mem_read", ex_mem_read, 0);
        chk("lu_bubble_ex_ctrl", ex_ctrl, 0);
        chk("lu_bubble_cnt", bubble_cnt, 1);
        chk("lu_stall_cleared", stall, 0);
        tick();
        chk("lu_capture_valid", ex_valid, 1);
        chk("lu_capture_rd", ex_rd, 9);
        chk("lu_capture_rs2_data", ex_rs2_data, 32'h0BADF00D);
        chk("lu_capture_ctrl", ex_ctrl, 8'h22);
        chk("lu_capture_cnt", bubble_cnt, 1);

        // Load with rd=x0 never stalls
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_mem_read = 1'b1;
        tick();
        settle();
        chk("x0_load_stall", stall, 0);

        // Flush together with a load-use hazard
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd7; id_mem_read = 1'b1;
        tick();
        id_rs1 = 5'd8; id_rs2 = 5'd7; id_rd = 5'd9; id_mem_read = 1'b0;
        settle();
        chk("fh_hazard_stall", stall, 1);
        flush = 1'b1;
        settle();
        chk("fh_stall", stall, 0);
        tick();
        flush = 1'b0;
        chk("fh_ex_valid", ex_valid, 0);
        chk("fh_ex_reg_write", ex_reg_write, 0);
        chk("fh_bubble_cnt", bubble_cnt, 2);
        chk("fh_sat_cnt", s_bubble_cnt, 2);

        // Saturation: both instances restarted, then 20 flushes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sat_rst_cnt", s_bubble_cnt, 0);
        flush = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_cnt_14", s_bubble_cnt, 14);
        tick();
        chk("sat_cnt_15", s_bubble_cnt, 15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold_15", s_bubble_cnt, 15);
        chk("wide_cnt_20", bubble_cnt, 20);

        // Reset during flush wins
        rst = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        chk("rst_mid_flush_cnt", bubble_cnt, 0);
        chk("rst_mid_flush_sat_cnt", s_bubble_cnt, 0);
        chk("rst_mid_flush_valid", ex_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
